// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, zero-register constant and packed-port field helper
//   Used by regfile_mp and regfile_scoreboard.
//   get_field(vec, i, w) returns bits [i*w +: w] of vec, zero-extended to VEC_MAX.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;
    localparam int ZERO_REG   = 0;
    localparam int VEC_MAX    = 1024;

    function automatic logic [VEC_MAX-1:0] get_field(input logic [VEC_MAX-1:0] vec, input int i, input int w);
        return (vec >> (i * w)) & ~({VEC_MAX{1'b1}} << w);
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-entry busy bits, reservation acceptance, flush and pending count
//   clk, rst_n    : clock, asynchronous active-low reset
//   rsv_en_i      : reserve the entry at rsv_addr_i
//   rsv_addr_i    : destination being issued
//   clr_i         : one bit per entry, set when a write targets it this cycle
//   flush_i       : clear every busy bit (reservations this cycle still apply)
//   busy_o        : registered busy vector
//   rsv_ok_o      : reservation accepted this cycle
//   pend_cnt_o    : registered count of busy entries
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rsv_en_i,
    input  logic [ADDR_W-1:0]      rsv_addr_i,
    input  logic [2**ADDR_W-1:0]   clr_i,
    input  logic                   flush_i,
    output logic [2**ADDR_W-1:0]   busy_o,
    output logic                   rsv_ok_o,
    output logic [ADDR_W:0]        pend_cnt_o
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d, set_vec;
    logic [ADDR_W:0]  pend_q, pend_d;

    // A write landing this cycle frees the entry, so a new reservation is safe.
    assign rsv_ok_o   = !busy_q[rsv_addr_i] || clr_i[rsv_addr_i];
    assign busy_o     = busy_q;
    assign pend_cnt_o = pend_q;

    // Set is ORed in after clear/flush so a same-cycle reservation wins.
    // Entry 0 is never set, which bounds the count at DEPTH-1.
    always_comb begin
        set_vec = '0;
        set_vec[rsv_addr_i] = rsv_en_i && rsv_ok_o && (rsv_addr_i != ADDR_W'(ZERO_REG));
        busy_d = (flush_i ? '0 : (busy_q & ~clr_i)) | set_vec;
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++) pend_d = pend_d + (ADDR_W+1)'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with hardwired zero entry and busy scoreboard
//   Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
//   clk, rst_n  : clock, asynchronous active-low reset
//   rd_addr_i   : NUM_RD read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data_o   : NUM_RD read data, port p at [p*DATA_W +: DATA_W]
//   rd_busy_o   : addressed entry has an outstanding reservation
//   wr_en_i / wr_addr_i / wr_data_i : NUM_WR write ports, highest index wins
//   rsv_en_i, rsv_addr_i, rsv_ok_o  : destination reservation handshake
//   flush_i     : clear all busy bits
//   pend_cnt_o  : number of busy entries
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic                     rsv_ok_o,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          pend_cnt_o
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  clr, busy;

    for (genvar g = 0; g < NUM_WR; g++) begin : g_wr
        assign wa[g] = ADDR_W'(get_field(VEC_MAX'(wr_addr_i), g, ADDR_W));
        assign wd[g] = DATA_W'(get_field(VEC_MAX'(wr_data_i), g, DATA_W));
    end
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign ra[g] = ADDR_W'(get_field(VEC_MAX'(rd_addr_i), g, ADDR_W));
    end

    // Ascending port order lets the highest-indexed port overwrite earlier ones.
    // Any write, including to entry 0, counts as a busy clear.
    always_comb begin
        mem_d = mem_q;
        clr = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) begin
                clr[wa[w]] = 1'b1;
                if (wa[w] != ZA) mem_d[wa[w]] = wd[w];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Entry 0 is never written or reserved, so its array value and busy bit stay 0.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_o[p*DATA_W +: DATA_W] = mem_q[ra[p]];
            rd_busy_o[p] = busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && wa[w] == ra[p] && ra[p] != ZA) begin
                    rd_data_o[p*DATA_W +: DATA_W] = wd[w];
                    rd_busy_o[p] = 1'b0;
                end
            end
`endif
        end
    end

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .clr_i      (clr),
        .flush_i    (flush_i),
        .busy_o     (busy),
        .rsv_ok_o   (rsv_ok_o),
        .pend_cnt_o (pend_cnt_o)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        rsv_ok;
    logic        flush = 1'b0;
    logic [5:0]  pend_cnt;
    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    logic        byp;

    regfile_mp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rsv_ok_o   (rsv_ok),
        .flush_i    (flush),
        .pend_cnt_o (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
`ifdef REGFILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        #3;
        check("reset_pend", 32'(pend_cnt), 0);
        check("reset_rd0", rd_data[31:0], 0);
        #10;
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            check("init_rd0", rd_data[31:0], 0);
            check("init_rd1", rd_data[63:32], 0);
            check("init_busy", 32'(rd_busy), 0);
        end
        // both ports hit entry 5: port 1 must win
        wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h5555, 32'hAAAA};
        tick();
        wr_en = 2'b00;
        rd(5'd5, 5'd0);
        check("wr_prio", rd_data[31:0], 32'h5555);
        // write to entry 0 is dropped
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFF_FFFF};
        tick();
        wr_en = 2'b00;
        rd(5'd0, 5'd5);
        check("zero_rd", rd_data[31:0], 0);
        check("zero_busy", 32'(rd_busy[0]), 0);
        check("keep5", rd_data[63:32], 32'h5555);
        // prime entry 7 with an old value, then same-cycle write/read
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h77};
        tick();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h1234};
        rd(5'd0, 5'd7);
        check("bypass_rd", rd_data[63:32], byp ? 32'h1234 : 32'h77);
        tick();
        wr_en = 2'b00;
        rd(5'd0, 5'd7);
        check("after_wr7", rd_data[63:32], 32'h1234);
        // scoreboard: reserve 9
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rd(5'd9, 5'd0);
        check("rsv9_ok", 32'(rsv_ok), 1);
        tick();
        check("rsv9_busy", 32'(rd_busy[0]), 1);
        check("rsv9_pend", 32'(pend_cnt), 1);
        check("rsv9_again", 32'(rsv_ok), 0);
        tick();
        check("refused_pend", 32'(pend_cnt), 1);
        rsv_en = 1'b0;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        #1;
        check("wr9_byp_busy", 32'(rd_busy[0]), byp ? 0 : 1);
        tick();
        wr_en = 2'b00;
        #1;
        check("wr9_clear", 32'(rd_busy[0]), 0);
        check("wr9_pend", 32'(pend_cnt), 0);
        check("wr9_data", rd_data[31:0], 32'h99);
        // reserve 9, then write and re-reserve 9 in the same cycle
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h9A};
        #1;
        check("wr_rsv_ok", 32'(rsv_ok), 1);
        tick();
        wr_en = 2'b00;
        rsv_addr = 5'd0;
        #1;
        check("set_wins_busy", 32'(rd_busy[0]), 1);
        check("set_wins_pend", 32'(pend_cnt), 1);
        check("rsv0_ok", 32'(rsv_ok), 1);
        tick();
        rsv_en = 1'b0;
        rd(5'd0, 5'd9);
        check("rsv0_pend", 32'(pend_cnt), 1);
        check("rsv0_busy", 32'(rd_busy[0]), 0);
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h9B, 32'h0};
        tick();
        wr_en = 2'b00;
        #1;
        check("clr9_pend", 32'(pend_cnt), 0);
        // reserve 3, 4, 5 then flush with a reservation on 6
        rsv_en = 1'b1;
        rsv_addr = 5'd3; tick();
        rsv_addr = 5'd4; tick();
        rsv_addr = 5'd5; tick();
        rsv_en = 1'b0;
        #1;
        check("pend3", 32'(pend_cnt), 3);
        rsv_en = 1'b1; rsv_addr = 5'd6; flush = 1'b1;
        tick();
        rsv_en = 1'b0; flush = 1'b0;
        rd(5'd6, 5'd3);
        check("flush_busy6", 32'(rd_busy[0]), 1);
        check("flush_busy3", 32'(rd_busy[1]), 0);
        rd(5'd4, 5'd5);
        check("flush_busy45", 32'(rd_busy), 0);
        check("flush_pend", 32'(pend_cnt), 1);
        // asynchronous reset mid-cycle
        rd(5'd5, 5'd7);
        check("pre_rst5", rd_data[31:0], 32'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd5", rd_data[31:0], 0);
        check("arst_rd7", rd_data[63:32], 0);
        check("arst_pend", 32'(pend_cnt), 0);
        rd(5'd6, 5'd9);
        check("arst_busy", 32'(rd_busy), 0);
        check("arst_rd9", rd_data[63:32], 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 32-bit MIPS datapath. It generalises the single-write, two-read register file with several configurable items: read and write port counts, data width, depth, clocked writes, and a hardwired zero register. It adds a per-entry busy scoreboard so the pipeline can detect reads of registers whose producing instruction has not yet written back. It sits between decode (reads, reservations) and write-back (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  addressed entry has an outstanding reservation
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  reserve (mark busy) the entry at rsv_addr
- rsv_addr  in  ADDR_W  destination being issued
- rsv_ok  out  1  reservation accepted this cycle
- flush  in  1  clear all busy bits (pipeline squash)
- pend_cnt  out  ADDR_W+1  number of busy entries

## Operation
- Reset: every entry is 0, every busy bit is 0, and pend_cnt is 0. rd_data is therefore 0 and rd_busy is 0 while rst_n is low.
- Entry 0 is hardwired to zero:
  - Writes to it are dropped.
  - Reservations to it are ignored, but rsv_ok is still 1.
  - Reads of it return 0 with rd_busy 0.
- Writes are synchronous. On a rising edge with wr_en[w] and wr_addr[w]≠0, the entry takes wr_data[w].
- Two write ports to the same address in one cycle: the highest port index wins.
- Reads are combinational from the array.
- Scoreboard, per entry:
  - A busy bit is set on an edge with rsv_en & rsv_ok & rsv_addr≠0.
  - A busy bit is cleared on an edge where any wr_en targets that entry.
- rsv_ok = !busy[rsv_addr] | (entry written this cycle). A reservation against a busy entry is refused (WAW stall); decode must hold rsv_en until rsv_ok.
- Set and clear of the same entry in the same cycle: the set wins, and the entry stays busy.
- flush clears all busy bits on the edge. If rsv_en is accepted in the same cycle, that reservation is still applied; data writes in a flush cycle proceed normally.
- pend_cnt is a registered population count. It is updated on the same edge as the busy bits and is never more than 2**ADDR_W−1.

## Timing
- Write latency is one edge: a read in the cycle after the write edge returns the new value.
- Busy set and clear take one edge; rd_busy and rsv_ok reflect the registered state, adjusted by bypass when it is enabled.
- Read path is combinational with no added latency.
- Asserting reset mid-operation immediately zeroes the array, busy bits and pend_cnt, regardless of clk.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches an active write in the same cycle returns that write's wr_data (highest port index wins), and rd_busy for that port is 0.
  - Entry 0 is never bypassed.
- REGFILE_BYPASS_EN undefined: reads return the pre-edge array contents and rd_busy reflects the registered busy bit only.
- rsv_ok's write-clear term is present in both builds.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD/NUM_WR localparams
  - a ZERO_REG constant (0)
  - a function extracting field i from a packed port vector
- Sub-module regfile_scoreboard holds:
  - the busy vector
  - rsv_ok
  - flush handling
  - the pend_cnt counter
- The top module holds the storage array, the write-priority logic and the read/bypass muxes.

## Test plan
- Reset, then read all 32 entries on both ports → all 0 and rd_busy=0. Assert rst_n low mid-run after writes → all reads 0 immediately.
- wr_en=2'b11, both addresses 5, data 0xAAAA/0x5555 → next cycle a read of 5 returns 0x5555. Write 0xFFFFFFFF to entry 0 → a read of 0 returns 0.
- With bypass: write 0x1234 to 7 and read 7 in the same cycle → rd_data 0x1234. Without bypass → the old value, with 0x1234 on the next cycle.
- Scoreboard: reserve 9 → next cycle rd_busy=1 for 9 and pend_cnt=1. Reserve 9 again → rsv_ok=0. Write 9 → busy clears and pend_cnt=0.
- Write 9 and reserve 9 in the same cycle → rsv_ok=1 and 9 stays busy. Reserve 0 → rsv_ok=1, pend_cnt unchanged.
- Reserve 3, 4, 5 → pend_cnt=3. flush together with rsv_en on 6 → next cycle only 6 is busy and pend_cnt=1.
